// File: rtl/chi_best_sel.sv
// Chi-square selector: snapshots NCHAN chi values, then returns either a
// chosen channel or the minimum valid chi, with a pass/fail against a threshold.
module chi_best_sel #(
    parameter int PARAMETERBITS = 14,
    parameter int NCHAN         = 4,
    parameter int IDXW          = 2
) (
    input  logic                           CLOCK,
    input  logic                           RESET_N,
    input  logic                           START,
    input  logic [1:0]                     MODE,
    input  logic [IDXW-1:0]                SEL,
    input  logic [NCHAN*PARAMETERBITS-1:0] CHI_IN,
    input  logic [NCHAN-1:0]               CHI_VALID,
    input  logic [PARAMETERBITS-1:0]       THRESH,
    output logic                           BUSY,
    output logic                           DONE,
    output logic [PARAMETERBITS-1:0]       CHI,
    output logic [IDXW-1:0]                CHI_IDX,
    output logic                           PASS,
    output logic                           NONE,
    output logic [1:0]                     DBG_STATE
);

    // Handshake: START is a request honoured only while the FSM is idle; any
    // START seen while busy is dropped. DONE is a one-cycle strobe marking the
    // cycle in which CHI/CHI_IDX/PASS/NONE carry a fresh result.

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCAN   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHAN - 1);

    state_t                           state_q, state_d;
    logic [NCHAN*PARAMETERBITS-1:0]   chi_sh_q, chi_sh_d;
    logic [NCHAN-1:0]                 vld_sh_q, vld_sh_d;
    logic [PARAMETERBITS-1:0]         thr_q, thr_d;
    logic                             min_mode_q, min_mode_d;
    logic [IDXW-1:0]                  sel_q, sel_d;
    logic [IDXW-1:0]                  cnt_q, cnt_d;
    logic [PARAMETERBITS-1:0]         best_q, best_d;
    logic [IDXW-1:0]                  best_idx_q, best_idx_d;
    logic                             found_q, found_d;
    logic [PARAMETERBITS-1:0]         chi_q, chi_d;
    logic [IDXW-1:0]                  idx_q, idx_d;
    logic                             pass_q, pass_d;
    logic                             none_q, none_d;
    logic                             done_q, done_d;
    logic                             busy_q, busy_d;

    logic [PARAMETERBITS-1:0]         cur_chi, fix_chi;
    logic                             cur_vld, fix_vld;

    // Channel muxes for the scan pointer and the fixed-mode selection.
    always_comb begin
        cur_chi = '0;
        cur_vld = 1'b0;
        fix_chi = '0;
        fix_vld = 1'b0;
        for (int k = 0; k < NCHAN; k++) begin
            if (cnt_q == IDXW'(k)) begin
                cur_chi = chi_sh_q[k*PARAMETERBITS +: PARAMETERBITS];
                cur_vld = vld_sh_q[k];
            end
            if (sel_q == IDXW'(k)) begin
                fix_chi = chi_sh_q[k*PARAMETERBITS +: PARAMETERBITS];
                fix_vld = vld_sh_q[k];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        chi_sh_d   = chi_sh_q;
        vld_sh_d   = vld_sh_q;
        thr_d      = thr_q;
        min_mode_d = min_mode_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        found_d    = found_q;
        chi_d      = chi_q;
        idx_d      = idx_q;
        pass_d     = pass_q;
        none_d     = none_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    chi_sh_d   = CHI_IN;
                    vld_sh_d   = CHI_VALID;
                    thr_d      = THRESH;
                    min_mode_d = (MODE == 2'b01);
                    // Out-of-range indices fall back to channel 0 at capture.
                    sel_d      = (int'(SEL) >= NCHAN) ? '0 : SEL;
                    if (MODE == 2'b01) begin
                        state_d    = S_SCAN;
                        cnt_d      = '0;
                        best_d     = '1;
                        best_idx_d = '0;
                        found_d    = 1'b0;
                    end else begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_SCAN: begin
                // Strict less-than so the lowest index wins a tie.
                if (cur_vld && (!found_q || (cur_chi < best_q))) begin
                    best_d     = cur_chi;
                    best_idx_d = cnt_q;
                    found_d    = 1'b1;
                end
                if (cnt_q == LAST_IDX) begin
                    state_d = S_FINISH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FINISH: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
                if (min_mode_q) begin
                    chi_d  = best_q;
                    idx_d  = best_idx_q;
                    none_d = !found_q;
                    pass_d = found_q && (best_q <= thr_q);
                end else begin
                    chi_d  = fix_chi;
                    idx_d  = sel_q;
                    none_d = !fix_vld;
                    pass_d = fix_vld && (fix_chi <= thr_q);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // BUSY covers the whole transaction including the DONE cycle.
    assign busy_d = (state_d != S_IDLE) || done_d;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= S_IDLE;
            chi_sh_q   <= '0;
            vld_sh_q   <= '0;
            thr_q      <= '0;
            min_mode_q <= 1'b0;
            sel_q      <= '0;
            cnt_q      <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            found_q    <= 1'b0;
            chi_q      <= '0;
            idx_q      <= '0;
            pass_q     <= 1'b0;
            none_q     <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            chi_sh_q   <= chi_sh_d;
            vld_sh_q   <= vld_sh_d;
            thr_q      <= thr_d;
            min_mode_q <= min_mode_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            found_q    <= found_d;
            chi_q      <= chi_d;
            idx_q      <= idx_d;
            pass_q     <= pass_d;
            none_q     <= none_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign CHI       = chi_q;
    assign CHI_IDX   = idx_q;
    assign PASS      = pass_q;
    assign NONE      = none_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_chi_best_sel.sv
// Directed bench for chi_best_sel: a 4-channel instance for the main scenarios
// and a 3-channel instance for out-of-range select and reserved mode.
module tb_chi_best_sel;

    localparam int W = 14;

    logic            clk;
    logic            rst_n;

    logic            st4;
    logic [1:0]      mode4;
    logic [1:0]      sel4;
    logic [4*W-1:0]  chi4;
    logic [3:0]      vld4;
    logic [W-1:0]    thr4;
    logic            busy4, done4, pass4, none4;
    logic [W-1:0]    chio4;
    logic [1:0]      idx4, dbg4;

    logic            st3;
    logic [1:0]      mode3;
    logic [1:0]      sel3;
    logic [3*W-1:0]  chi3;
    logic [2:0]      vld3;
    logic [W-1:0]    thr3;
    logic            busy3, done3, pass3, none3;
    logic [W-1:0]    chio3;
    logic [1:0]      idx3, dbg3;

    int checks = 0;
    int errors = 0;

    chi_best_sel #(.PARAMETERBITS(W), .NCHAN(4), .IDXW(2)) u4 (
        .CLOCK(clk), .RESET_N(rst_n), .START(st4), .MODE(mode4), .SEL(sel4),
        .CHI_IN(chi4), .CHI_VALID(vld4), .THRESH(thr4), .BUSY(busy4),
        .DONE(done4), .CHI(chio4), .CHI_IDX(idx4), .PASS(pass4), .NONE(none4),
        .DBG_STATE(dbg4)
    );

    chi_best_sel #(.PARAMETERBITS(W), .NCHAN(3), .IDXW(2)) u3 (
        .CLOCK(clk), .RESET_N(rst_n), .START(st3), .MODE(mode3), .SEL(sel3),
        .CHI_IN(chi3), .CHI_VALID(vld3), .THRESH(thr3), .BUSY(busy3),
        .DONE(done3), .CHI(chio3), .CHI_IDX(idx3), .PASS(pass3), .NONE(none3),
        .DBG_STATE(dbg3)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4*W-1:0] pack4(input int a, input int b, input int c, input int d);
        return {W'(d), W'(c), W'(b), W'(a)};
    endfunction

    // Drivers: inputs are set away from the edge, START held across one rising edge.
    task automatic drive4(input logic [1:0] m, input logic [1:0] s,
                          input logic [4*W-1:0] c, input logic [3:0] v, input int t);
        mode4 = m; sel4 = s; chi4 = c; vld4 = v; thr4 = W'(t);
        st4 = 1'b1;
        @(posedge clk);
        #1 st4 = 1'b0;
    endtask

    task automatic drive3(input logic [1:0] m, input logic [1:0] s,
                          input logic [3*W-1:0] c, input logic [2:0] v, input int t);
        mode3 = m; sel3 = s; chi3 = c; vld3 = v; thr3 = W'(t);
        st3 = 1'b1;
        @(posedge clk);
        #1 st3 = 1'b0;
    endtask

    // Counts falling edges after the START edge until DONE is seen; -1 on timeout.
    task automatic wait_done4(input int budget, output int lat);
        lat = -1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (done4) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        st4 = 1'b0; mode4 = 2'b00; sel4 = '0; chi4 = '0; vld4 = '0; thr4 = '0;
        st3 = 1'b0; mode3 = 2'b00; sel3 = '0; chi3 = '0; vld3 = '0; thr3 = '0;
        #3;
        checks++;
        if ({busy4, done4, chio4, idx4, pass4, none4} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b chi=%0d idx=%0d pass=%b none=%b, want all 0",
                     busy4, done4, chio4, idx4, pass4, none4);
        end
        checks++;
        if (dbg4 !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d, want 0", dbg4);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fixed;
        int lat;
        drive4(2'b00, 2'd2, pack4(100, 200, 300, 400), 4'b1111, 350);
        wait_done4(10, lat);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL fixed_latency: got %0d, want 2", lat);
        end
        checks++;
        if ({chio4, idx4, pass4, none4} !== {W'(300), 2'd2, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL fixed_sel2: got chi=%0d idx=%0d pass=%b none=%b, want 300 2 1 0",
                     chio4, idx4, pass4, none4);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({done4, chio4, idx4, pass4} !== {1'b0, W'(300), 2'd2, 1'b1}) begin
            errors++;
            $display("FAIL fixed_hold: got done=%b chi=%0d idx=%0d pass=%b, want 0 300 2 1",
                     done4, chio4, idx4, pass4);
        end
        drive4(2'b00, 2'd3, pack4(100, 200, 300, 400), 4'b1111, 350);
        wait_done4(10, lat);
        checks++;
        if ({chio4, idx4, pass4, none4} !== {W'(400), 2'd3, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL fixed_sel3: got chi=%0d idx=%0d pass=%b none=%b, want 400 3 0 0",
                     chio4, idx4, pass4, none4);
        end
        @(negedge clk);
        drive4(2'b00, 2'd1, pack4(100, 200, 300, 400), 4'b1101, 350);
        wait_done4(10, lat);
        checks++;
        if ({chio4, idx4, pass4, none4} !== {W'(200), 2'd1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL fixed_invalid: got chi=%0d idx=%0d pass=%b none=%b, want 200 1 0 1",
                     chio4, idx4, pass4, none4);
        end
        @(negedge clk);
    endtask

    task automatic test_min;
        int lat = -1;
        int bc = 0;
        logic [W+3:0] res = '0;
        drive4(2'b01, 2'd0, pack4(900, 50, 50, 700), 4'b1111, 49);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (busy4) bc++;
            if (done4 && lat < 0) begin
                lat = c;
                res = {chio4, idx4, pass4, none4};
            end
        end
        checks++;
        if (lat !== 6) begin
            errors++;
            $display("FAIL min_latency: got %0d, want 6", lat);
        end
        checks++;
        if (bc !== 6) begin
            errors++;
            $display("FAIL min_busy_cycles: got %0d, want 6", bc);
        end
        checks++;
        if (res !== {W'(50), 2'd1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL min_tie: got %h, want chi=50 idx=1 pass=0 none=0 (%h)",
                     res, {W'(50), 2'd1, 1'b0, 1'b0});
        end
    endtask

    task automatic test_valid_mask;
        int lat;
        drive4(2'b01, 2'd0, pack4(10, 500, 20, 800), 4'b1010, 1000);
        wait_done4(12, lat);
        checks++;
        if ({lat, chio4, idx4, pass4, none4} !== {32'd6, W'(500), 2'd1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL mask_1010: got lat=%0d chi=%0d idx=%0d pass=%b none=%b, want 6 500 1 1 0",
                     lat, chio4, idx4, pass4, none4);
        end
        @(negedge clk);
        drive4(2'b01, 2'd2, pack4(10, 500, 20, 800), 4'b0000, 16383);
        wait_done4(12, lat);
        checks++;
        if ({chio4, idx4, pass4, none4} !== {W'(16383), 2'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL mask_0000: got chi=%0d idx=%0d pass=%b none=%b, want 16383 0 0 1",
                     chio4, idx4, pass4, none4);
        end
        @(negedge clk);
    endtask

    task automatic test_busy_reject;
        int dones = 0;
        logic [W+3:0] res = '0;
        drive4(2'b01, 2'd0, pack4(40, 30, 20, 60), 4'b1111, 25);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        mode4 = 2'b00; sel4 = 2'd0; chi4 = pack4(1, 1, 1, 1); thr4 = '0;
        st4 = 1'b1;
        @(posedge clk);
        #1 st4 = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done4) begin
                dones++;
                res = {chio4, idx4, pass4, none4};
            end
        end
        checks++;
        if (dones !== 1) begin
            errors++;
            $display("FAIL busy_one_done: got %0d DONE pulses, want 1", dones);
        end
        checks++;
        if (res !== {W'(20), 2'd2, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL busy_first_snapshot: got %h, want chi=20 idx=2 pass=1 none=0 (%h)",
                     res, {W'(20), 2'd2, 1'b1, 1'b0});
        end
    endtask

    task automatic test_back_to_back;
        int lat1, lat2;
        drive4(2'b01, 2'd0, pack4(5, 6, 7, 8), 4'b1111, 100);
        wait_done4(12, lat1);
        checks++;
        if ({lat1, chio4, idx4} !== {32'd6, W'(5), 2'd0}) begin
            errors++;
            $display("FAIL b2b_first: got lat=%0d chi=%0d idx=%0d, want 6 5 0", lat1, chio4, idx4);
        end
        drive4(2'b01, 2'd0, pack4(9, 3, 9, 9), 4'b1111, 2);
        wait_done4(12, lat2);
        checks++;
        if ({lat2, chio4, idx4, pass4} !== {32'd6, W'(3), 2'd1, 1'b0}) begin
            errors++;
            $display("FAIL b2b_second: got lat=%0d chi=%0d idx=%0d pass=%b, want 6 3 1 0",
                     lat2, chio4, idx4, pass4);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int dones = 0;
        int lat;
        drive4(2'b01, 2'd0, pack4(100, 200, 300, 400), 4'b1111, 1000);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy4, done4, chio4, idx4, pass4, none4} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got busy=%b done=%b chi=%0d idx=%0d pass=%b none=%b, want all 0",
                     busy4, done4, chio4, idx4, pass4, none4);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done4) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL reset_mid_no_done: got %0d DONE pulses, want 0", dones);
        end
        rst_n = 1'b1;
        @(negedge clk);
        drive4(2'b00, 2'd0, pack4(123, 7, 8, 9), 4'b1111, 200);
        wait_done4(10, lat);
        checks++;
        if ({lat, chio4, idx4, pass4} !== {32'd2, W'(123), 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid_recover: got lat=%0d chi=%0d idx=%0d pass=%b, want 2 123 0 1",
                     lat, chio4, idx4, pass4);
        end
        @(negedge clk);
    endtask

    task automatic test_nchan3;
        int lat;
        drive3(2'b00, 2'd3, {W'(33), W'(22), W'(11)}, 3'b111, 15);
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (done3) begin lat = c; break; end
        end
        checks++;
        if ({lat, chio3, idx3, pass3, none3} !== {32'd2, W'(11), 2'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL n3_sel_oob: got lat=%0d chi=%0d idx=%0d pass=%b none=%b, want 2 11 0 1 0",
                     lat, chio3, idx3, pass3, none3);
        end
        @(negedge clk);
        drive3(2'b11, 2'd1, {W'(33), W'(22), W'(11)}, 3'b111, 15);
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (done3) begin lat = c; break; end
        end
        checks++;
        if ({lat, chio3, idx3, pass3, none3} !== {32'd2, W'(22), 2'd1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL n3_mode_11: got lat=%0d chi=%0d idx=%0d pass=%b none=%b, want 2 22 1 0 0",
                     lat, chio3, idx3, pass3, none3);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_fixed;
        test_min;
        test_valid_mask;
        test_busy_reject;
        test_back_to_back;
        test_reset_mid;
        test_nchan3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
